// File: rtl/uart_cmd_decode_if.sv
// Byte-stream and payload-FIFO signals between uart_rx, uart_cmd_decode and the SDRAM write side.
// Handshakes: po_flag is a one-cycle valid with no ready; the producer never stalls.
// wfifo_rd_en pops only when wfifo_empty=0, and the byte appears on wfifo_rd_data one cycle later.
interface uart_cmd_decode_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          po_flag;
    logic [7:0]    rx_data;
    logic          wr_trig;
    logic          rd_trig;
    logic          frame_err;
    logic          wfifo_rd_en;
    logic [7:0]    wfifo_rd_data;
    logic          wfifo_empty;
    logic [CW-1:0] wfifo_cnt;

    modport slave (
        input  po_flag, rx_data, wfifo_rd_en,
        output wr_trig, rd_trig, frame_err, wfifo_rd_data, wfifo_empty, wfifo_cnt
    );

    modport master (
        output po_flag, rx_data, wfifo_rd_en,
        input  wr_trig, rd_trig, frame_err, wfifo_rd_data, wfifo_empty, wfifo_cnt
    );
endinterface

// File: rtl/uart_cmd_decode.sv
// Parses UART header/command/payload frames into SDRAM write/read triggers.
// Write payload is staged in a FIFO and becomes visible to the reader only on frame completion.
module uart_cmd_decode #(
    parameter int         WR_LEN      = 4,
    parameter int         FIFO_DEPTH  = 16,
    parameter int         TIMEOUT_CYC = 200000,
    parameter logic [7:0] HDR         = 8'h55,
    parameter logic [7:0] CMD_WR      = 8'hAA,
    parameter logic [7:0] CMD_RD      = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    uart_cmd_decode_if.slave  bus,
    output logic [1:0]        dbg_state_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LEN_C    = CW'(WR_LEN);
    localparam logic [CW-1:0] LEN_LAST = CW'(WR_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_WDATA = 2'd2
    } state_e;

    state_e        state_q, state_d;
    // Pointers carry one extra wrap bit so a full FIFO is distinguishable from empty.
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] commit_ptr_q, commit_ptr_d;
    logic [CW-1:0] rd_ptr_q;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          wr_trig_q, wr_trig_d;
    logic          rd_trig_q, rd_trig_d;
    logic          err_q, err_d;
    logic [7:0]    rd_data_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [CW-1:0] cnt;
    logic          pop;
    logic          mem_we;
    logic          space_ok;

    assign cnt      = commit_ptr_q - rd_ptr_q;
    assign pop      = bus.wfifo_rd_en && (cnt != '0);
    assign space_ok = (DEPTH_C - cnt) >= LEN_C;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        bcnt_d       = bcnt_q;
        tmo_d        = '0;
        wr_trig_d    = 1'b0;
        rd_trig_d    = 1'b0;
        err_d        = 1'b0;
        mem_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.po_flag && bus.rx_data == HDR) state_d = S_CMD;
            end
            S_CMD: begin
                if (bus.po_flag) begin
                    if (bus.rx_data == CMD_RD) begin
                        rd_trig_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (bus.rx_data == CMD_WR && space_ok) begin
                        bcnt_d   = '0;
                        wr_ptr_d = commit_ptr_q;
                        state_d  = S_WDATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WDATA: begin
                if (bus.po_flag) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (bcnt_q == LEN_LAST) begin
                        commit_ptr_d = wr_ptr_q + 1'b1;
                        wr_trig_d    = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte arriving in the timeout cycle wins because only idle cycles count.
        if (state_q != S_IDLE && !bus.po_flag) begin
            if (tmo_q == TMO_LAST) begin
                err_d    = 1'b1;
                wr_ptr_d = commit_ptr_q;
                state_d  = S_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            bcnt_q       <= '0;
            tmo_q        <= '0;
            wr_trig_q    <= 1'b0;
            rd_trig_q    <= 1'b0;
            err_q        <= 1'b0;
            rd_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            bcnt_q       <= bcnt_d;
            tmo_q        <= tmo_d;
            wr_trig_q    <= wr_trig_d;
            rd_trig_q    <= rd_trig_d;
            err_q        <= err_d;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

    // Writes only target uncommitted slots, so they never collide with a pop.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= bus.rx_data;
    end

    assign bus.wr_trig       = wr_trig_q;
    assign bus.rd_trig       = rd_trig_q;
    assign bus.frame_err     = err_q;
    assign bus.wfifo_rd_data = rd_data_q;
    assign bus.wfifo_empty   = (cnt == '0);
    assign bus.wfifo_cnt     = cnt;
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_uart_cmd_decode.sv
// Directed bench for uart_cmd_decode: frame parsing, commit gating, timeout, full FIFO and pop overlap.
module tb_uart_cmd_decode;
    localparam int WR_LEN      = 4;
    localparam int FIFO_DEPTH  = 8;
    localparam int TIMEOUT_CYC = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_cmd_decode_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus();

    uart_cmd_decode #(
        .WR_LEN(WR_LEN), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC),
        .HDR(8'h55), .CMD_WR(8'hAA), .CMD_RD(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: sim time expired, exp finish");
        $fatal(1, "watchdog");
    end

    // All tasks leave time at 1 ns after a rising edge; registered outputs are stable there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.po_flag = 1'b1;
        bus.rx_data = b;
        tick();
        bus.po_flag = 1'b0;
    endtask

    task automatic do_pop();
        bus.wfifo_rd_en = 1'b1;
        tick();
        bus.wfifo_rd_en = 1'b0;
    endtask

    task automatic send_write(input logic [7:0] d0, d1, d2, d3);
        send_byte(8'h55); send_byte(8'hAA);
        send_byte(d0); send_byte(d1); send_byte(d2); send_byte(d3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.wfifo_empty !== 1'b1 || bus.wfifo_cnt !== 4'd0) begin
            n_fail++; $display("FAIL reset_fifo: empty=%b cnt=%0d exp empty=1 cnt=0", bus.wfifo_empty, bus.wfifo_cnt);
        end
        n_checks++;
        if (bus.wfifo_rd_data !== 8'h00 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_data_state: data=%h state=%0d exp 00/0", bus.wfifo_rd_data, dbg_state);
        end
        n_checks++;
        if ({bus.wr_trig, bus.rd_trig, bus.frame_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b exp 000", {bus.wr_trig, bus.rd_trig, bus.frame_err});
        end
    endtask

    task automatic test_write_frame();
        send_byte(8'h55); send_byte(8'hAA);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        n_checks++;
        if (bus.wr_trig !== 1'b0 || bus.wfifo_cnt !== 4'd0) begin
            n_fail++; $display("FAIL wr_partial: trig=%b cnt=%0d exp 0/0", bus.wr_trig, bus.wfifo_cnt);
        end
        send_byte(8'h44);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        n_checks++;
        if (bus.wr_trig !== 1'b1 || bus.wfifo_cnt !== 4'd4) begin
            n_fail++; $display("FAIL wr_commit: trig=%b cnt=%0d exp 1/4", bus.wr_trig, bus.wfifo_cnt);
        end
        tick();
        n_checks++;
        if (bus.wr_trig !== 1'b0) begin
            n_fail++; $display("FAIL wr_pulse_width: trig=%b exp 0", bus.wr_trig);
        end
        for (int i = 0; i < 4; i++) begin
            do_pop();
            exp_b = exp_q.pop_front();
            n_checks++;
            if (bus.wfifo_rd_data !== exp_b) begin
                n_fail++; $display("FAIL wr_pop%0d: got %h exp %h", i, bus.wfifo_rd_data, exp_b);
            end
        end
        n_checks++;
        if (bus.wfifo_empty !== 1'b1 || bus.wfifo_cnt !== 4'd0) begin
            n_fail++; $display("FAIL wr_drained: empty=%b cnt=%0d exp 1/0", bus.wfifo_empty, bus.wfifo_cnt);
        end
    endtask

    task automatic test_read_cmd();
        send_byte(8'h55); send_byte(8'hA5);
        n_checks++;
        if (bus.rd_trig !== 1'b1 || bus.wr_trig !== 1'b0 || bus.wfifo_cnt !== 4'd0) begin
            n_fail++; $display("FAIL rd_trig: rd=%b wr=%b cnt=%0d exp 1/0/0", bus.rd_trig, bus.wr_trig, bus.wfifo_cnt);
        end
        tick();
        n_checks++;
        if (bus.rd_trig !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL rd_pulse_width: rd=%b state=%0d exp 0/0", bus.rd_trig, dbg_state);
        end
    endtask

    task automatic test_timeout();
        int seen;
        seen = -1;
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h11); send_byte(8'h22);
        for (int i = 1; i <= 110 && seen < 0; i++) begin
            tick();
            if (bus.frame_err === 1'b1) seen = i;
        end
        n_checks++;
        if (seen < 99 || seen > 101) begin
            n_fail++; $display("FAIL timeout_latency: err after %0d idle cycles exp about %0d", seen, TIMEOUT_CYC);
        end
        n_checks++;
        if (bus.wfifo_cnt !== 4'd0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL timeout_discard: cnt=%0d state=%0d exp 0/0", bus.wfifo_cnt, dbg_state);
        end
        send_write(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3); exp_q.push_back(8'hA4);
        n_checks++;
        if (bus.wr_trig !== 1'b1 || bus.wfifo_cnt !== 4'd4) begin
            n_fail++; $display("FAIL timeout_recover: trig=%b cnt=%0d exp 1/4", bus.wr_trig, bus.wfifo_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            do_pop();
            exp_b = exp_q.pop_front();
            n_checks++;
            if (bus.wfifo_rd_data !== exp_b) begin
                n_fail++; $display("FAIL timeout_pop%0d: got %h exp %h", i, bus.wfifo_rd_data, exp_b);
            end
        end
    endtask

    task automatic test_full();
        send_write(8'h01, 8'h02, 8'h03, 8'h04);
        send_write(8'h05, 8'h06, 8'h07, 8'h08);
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
        n_checks++;
        if (bus.wfifo_cnt !== 4'd8) begin
            n_fail++; $display("FAIL full_cnt: cnt=%0d exp 8", bus.wfifo_cnt);
        end
        send_byte(8'h55); send_byte(8'hAA);
        n_checks++;
        if (bus.frame_err !== 1'b1 || bus.wr_trig !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL full_reject: err=%b trig=%b state=%0d exp 1/0/0", bus.frame_err, bus.wr_trig, dbg_state);
        end
        for (int i = 0; i < 4; i++) begin
            do_pop();
            exp_b = exp_q.pop_front();
            n_checks++;
            if (bus.wfifo_rd_data !== exp_b) begin
                n_fail++; $display("FAIL full_pop%0d: got %h exp %h", i, bus.wfifo_rd_data, exp_b);
            end
        end
        send_write(8'h09, 8'h0A, 8'h0B, 8'h0C);
        for (int i = 9; i <= 12; i++) exp_q.push_back(8'(i));
        n_checks++;
        if (bus.wr_trig !== 1'b1 || bus.wfifo_cnt !== 4'd8) begin
            n_fail++; $display("FAIL full_resend: trig=%b cnt=%0d exp 1/8", bus.wr_trig, bus.wfifo_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            do_pop();
            exp_b = exp_q.pop_front();
            n_checks++;
            if (bus.wfifo_rd_data !== exp_b) begin
                n_fail++; $display("FAIL wrap_pop%0d: got %h exp %h", i, bus.wfifo_rd_data, exp_b);
            end
        end
        n_checks++;
        if (bus.wfifo_empty !== 1'b1) begin
            n_fail++; $display("FAIL wrap_empty: empty=%b exp 1", bus.wfifo_empty);
        end
    endtask

    task automatic test_bad_cmd();
        send_byte(8'h55); send_byte(8'h7E);
        n_checks++;
        if (bus.frame_err !== 1'b1 || bus.wr_trig !== 1'b0 || bus.rd_trig !== 1'b0) begin
            n_fail++; $display("FAIL bad_cmd_err: err=%b wr=%b rd=%b exp 1/0/0", bus.frame_err, bus.wr_trig, bus.rd_trig);
        end
        send_byte(8'h33);
        n_checks++;
        if ({bus.frame_err, bus.wr_trig, bus.rd_trig} !== 3'b000 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL stray_byte: pulses=%b state=%0d exp 000/0", {bus.frame_err, bus.wr_trig, bus.rd_trig}, dbg_state);
        end
    endtask

    task automatic test_payload_hdr();
        send_write(8'h55, 8'hAA, 8'hA5, 8'h55);
        exp_q.push_back(8'h55); exp_q.push_back(8'hAA); exp_q.push_back(8'hA5); exp_q.push_back(8'h55);
        n_checks++;
        if (bus.wr_trig !== 1'b1 || bus.wfifo_cnt !== 4'd4) begin
            n_fail++; $display("FAIL hdr_payload_commit: trig=%b cnt=%0d exp 1/4", bus.wr_trig, bus.wfifo_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            do_pop();
            exp_b = exp_q.pop_front();
            n_checks++;
            if (bus.wfifo_rd_data !== exp_b) begin
                n_fail++; $display("FAIL hdr_payload_pop%0d: got %h exp %h", i, bus.wfifo_rd_data, exp_b);
            end
        end
    endtask

    task automatic test_back_to_back();
        send_write(8'hB1, 8'hB2, 8'hB3, 8'hB4);
        exp_q.push_back(8'hB1); exp_q.push_back(8'hB2); exp_q.push_back(8'hB3); exp_q.push_back(8'hB4);
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        bus.po_flag     = 1'b1;
        bus.rx_data     = 8'hC4;
        bus.wfifo_rd_en = 1'b1;
        tick();
        bus.po_flag     = 1'b0;
        bus.wfifo_rd_en = 1'b0;
        exp_b = exp_q.pop_front();
        exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3); exp_q.push_back(8'hC4);
        n_checks++;
        if (bus.wfifo_cnt !== 4'd7 || bus.wr_trig !== 1'b1) begin
            n_fail++; $display("FAIL commit_pop_cnt: cnt=%0d trig=%b exp 7/1", bus.wfifo_cnt, bus.wr_trig);
        end
        n_checks++;
        if (bus.wfifo_rd_data !== exp_b) begin
            n_fail++; $display("FAIL commit_pop_data: got %h exp %h", bus.wfifo_rd_data, exp_b);
        end
        for (int i = 0; i < 7; i++) begin
            do_pop();
            exp_b = exp_q.pop_front();
            n_checks++;
            if (bus.wfifo_rd_data !== exp_b) begin
                n_fail++; $display("FAIL b2b_pop%0d: got %h exp %h", i, bus.wfifo_rd_data, exp_b);
            end
        end
        do_pop();
        n_checks++;
        if (bus.wfifo_rd_data !== 8'hC4 || bus.wfifo_cnt !== 4'd0 || bus.wfifo_empty !== 1'b1) begin
            n_fail++; $display("FAIL empty_pop: data=%h cnt=%0d empty=%b exp C4/0/1", bus.wfifo_rd_data, bus.wfifo_cnt, bus.wfifo_empty);
        end
    endtask

    task automatic test_reset_midframe();
        send_write(8'hD1, 8'hD2, 8'hD3, 8'hD4);
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.wfifo_cnt !== 4'd0 || bus.wfifo_empty !== 1'b1 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_midframe: cnt=%0d empty=%b state=%0d exp 0/1/0", bus.wfifo_cnt, bus.wfifo_empty, dbg_state);
        end
        send_write(8'hE1, 8'hE2, 8'hE3, 8'hE4);
        exp_q.push_back(8'hE1); exp_q.push_back(8'hE2); exp_q.push_back(8'hE3); exp_q.push_back(8'hE4);
        for (int i = 0; i < 4; i++) begin
            do_pop();
            exp_b = exp_q.pop_front();
            n_checks++;
            if (bus.wfifo_rd_data !== exp_b) begin
                n_fail++; $display("FAIL post_reset_pop%0d: got %h exp %h", i, bus.wfifo_rd_data, exp_b);
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.po_flag     = 1'b0;
        bus.rx_data     = 8'h00;
        bus.wfifo_rd_en = 1'b0;
        test_reset();
        test_write_frame();
        test_read_cmd();
        test_timeout();
        test_full();
        test_bad_cmd();
        test_payload_hdr();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
